// File: rtl/parallel_ntt_stream.sv
// Streaming N-point NTT / inverse NTT over Z_q with natural-order input and output.
// Radix-2 DIT on a bit-reversed coefficient store, LANES butterflies issued per cycle.

module parallel_ntt_stream #(
    parameter int unsigned      WIDTH     = 64,
    parameter int unsigned      LOGN      = 12,
    parameter int unsigned      LANES     = 8,
    parameter logic [WIDTH-1:0] MODULUS   = 64'hffffffff00000001,
    // A zero root/inverse selects derivation from generator 7 of the default field.
    parameter logic [WIDTH-1:0] OMEGA     = '0,
    parameter logic [WIDTH-1:0] OMEGA_INV = '0,
    parameter logic [WIDTH-1:0] N_INV     = '0,
    parameter int unsigned      MUL_LAT   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             len_err,
    output logic [31:0]      frame_count
);

    localparam int unsigned N      = 1 << LOGN;
    localparam int unsigned HALF   = N / 2;
    localparam int unsigned BF_CYC = HALF / LANES;
    localparam int unsigned SC_CYC = N / LANES;
    localparam int unsigned CW     = LOGN + 1;

    function automatic logic [WIDTH-1:0] mul_mod(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] p;
        p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        return WIDTH'(p % {{WIDTH{1'b0}}, MODULUS});
    endfunction

    function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, MODULUS}) s = s - {1'b0, MODULUS};
        return s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH:0] d;
        d = {1'b0, a} + {1'b0, MODULUS} - {1'b0, b};
        if (d >= {1'b0, MODULUS}) d = d - {1'b0, MODULUS};
        return d[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] pow_mod(input logic [WIDTH-1:0] b,
                                                 input logic [WIDTH-1:0] e);
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] x;
        r = WIDTH'(1);
        x = b;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (e[i]) r = mul_mod(r, x);
            x = mul_mod(x, x);
        end
        return r;
    endfunction

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
        logic [LOGN-1:0] r;
        for (int i = 0; i < int'(LOGN); i++) r[i] = v[LOGN-1-i];
        return r;
    endfunction

    localparam logic [WIDTH-1:0] W_F = (OMEGA != '0) ? OMEGA :
        pow_mod(WIDTH'(7), (MODULUS - WIDTH'(1)) >> LOGN);
    localparam logic [WIDTH-1:0] W_I = (OMEGA_INV != '0) ? OMEGA_INV :
        pow_mod(W_F, MODULUS - WIDTH'(2));
    localparam logic [WIDTH-1:0] N_I = (N_INV != '0) ? N_INV :
        pow_mod(pow_mod(WIDTH'(2), WIDTH'(LOGN)), MODULUS - WIDTH'(2));

    typedef enum logic [2:0] {StInit, StIdle, StLoad, StCompute, StUnload} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [4:0]       stage_q, stage_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             len_err_q, len_err_d;
    logic [31:0]      fc_q, fc_d;
    logic [WIDTH-1:0] tw_f_cur_q, tw_i_cur_q;

    logic [WIDTH-1:0] mem  [N];
    logic [WIDTH-1:0] tw_f [HALF];
    logic [WIDTH-1:0] tw_i [HALF];

    logic             load_we, issue, last_stage, scale_stage;
    logic [CW-1:0]    issue_n;

    logic [MUL_LAT-1:0] pv_q, psc_q;
    logic [LOGN-1:0]    pi0_q [MUL_LAT][LANES];
    logic [LOGN-1:0]    pi1_q [MUL_LAT][LANES];
    logic [WIDTH-1:0]   pu_q  [MUL_LAT][LANES];
    logic [WIDTH-1:0]   pt_q  [MUL_LAT][LANES];

    logic [LOGN-1:0]    iss_i0 [LANES];
    logic [LOGN-1:0]    iss_i1 [LANES];
    logic [WIDTH-1:0]   iss_u  [LANES];
    logic [WIDTH-1:0]   iss_t  [LANES];

    assign scale_stage = (stage_q == 5'(LOGN));
    assign last_stage  = scale_stage || (!mode_q && stage_q == 5'(LOGN - 1));
    assign issue_n     = scale_stage ? CW'(SC_CYC) : CW'(BF_CYC);

    // Butterfly b of stage s pairs i0/i0+2^s inside a group of 2^(s+1).
    always_comb begin
        int unsigned      bi, hs, pos, i0, ti;
        logic [WIDTH-1:0] tw;
        for (int l = 0; l < int'(LANES); l++) begin
            bi        = 32'(cnt_q) * LANES + 32'(l);
            hs        = 32'd1 << stage_q;
            pos       = bi & (hs - 1);
            i0        = ((bi >> stage_q) << (stage_q + 1)) | pos;
            ti        = pos << (LOGN - 1 - 32'(stage_q));
            tw        = mode_q ? tw_i[(LOGN-1)'(ti)] : tw_f[(LOGN-1)'(ti)];
            iss_i0[l] = '0;
            iss_i1[l] = '0;
            iss_u[l]  = '0;
            iss_t[l]  = '0;
            if (scale_stage) begin
                iss_i0[l] = LOGN'(bi);
                iss_i1[l] = LOGN'(bi);
                iss_t[l]  = mul_mod(mem[LOGN'(bi)], N_I);
            end else begin
                iss_i0[l] = LOGN'(i0);
                iss_i1[l] = LOGN'(i0 | hs);
                iss_u[l]  = mem[LOGN'(i0)];
                iss_t[l]  = mul_mod(mem[LOGN'(i0 | hs)], tw);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stage_d   = stage_q;
        mode_d    = mode_q;
        done_d    = 1'b0;
        len_err_d = 1'b0;
        fc_d      = fc_q;
        in_ready  = 1'b0;
        busy      = 1'b1;
        load_we   = 1'b0;
        issue     = 1'b0;
        unique case (state_q)
            StInit: begin
                if (cnt_q == CW'(HALF - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StIdle: begin
                busy     = 1'b0;
                in_ready = 1'b1;
                if (in_valid) begin
                    load_we = 1'b1;
                    mode_d  = in_mode;
                    if (in_last) begin
                        len_err_d = 1'b1;
                    end else begin
                        state_d = StLoad;
                        cnt_d   = CW'(1);
                    end
                end
            end
            StLoad: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_we = 1'b1;
                    if (cnt_q == CW'(N - 1)) begin
                        state_d   = StCompute;
                        cnt_d     = '0;
                        stage_d   = '0;
                        len_err_d = !in_last;
                    end else if (in_last) begin
                        state_d   = StIdle;
                        cnt_d     = '0;
                        len_err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StCompute: begin
                if (cnt_q != issue_n) begin
                    issue = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end else if (pv_q == '0) begin
                    // Stage boundary only once every product of the stage has retired.
                    cnt_d = '0;
                    if (last_stage) state_d = StUnload;
                    else            stage_d = stage_q + 1'b1;
                end
            end
            StUnload: begin
                if (out_ready) begin
                    if (cnt_q == CW'(N - 1)) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        fc_d    = fc_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StInit;
            cnt_q      <= '0;
            stage_q    <= '0;
            mode_q     <= 1'b0;
            done_q     <= 1'b0;
            len_err_q  <= 1'b0;
            fc_q       <= '0;
            tw_f_cur_q <= WIDTH'(1);
            tw_i_cur_q <= WIDTH'(1);
            pv_q       <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stage_q   <= stage_d;
            mode_q    <= mode_d;
            done_q    <= done_d;
            len_err_q <= len_err_d;
            fc_q      <= fc_d;
            if (state_q == StInit) begin
                tw_f_cur_q <= mul_mod(tw_f_cur_q, W_F);
                tw_i_cur_q <= mul_mod(tw_i_cur_q, W_I);
            end
            pv_q[0] <= issue;
            for (int i = 1; i < int'(MUL_LAT); i++) pv_q[i] <= pv_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == StInit) begin
            tw_f[(LOGN-1)'(cnt_q)] <= tw_f_cur_q;
            tw_i[(LOGN-1)'(cnt_q)] <= tw_i_cur_q;
        end
        if (load_we) mem[bitrev(LOGN'(cnt_q))] <= in_data % MODULUS;
        psc_q[0] <= scale_stage;
        for (int i = 1; i < int'(MUL_LAT); i++) psc_q[i] <= psc_q[i-1];
        for (int l = 0; l < int'(LANES); l++) begin
            pi0_q[0][l] <= iss_i0[l];
            pi1_q[0][l] <= iss_i1[l];
            pu_q[0][l]  <= iss_u[l];
            pt_q[0][l]  <= iss_t[l];
            for (int i = 1; i < int'(MUL_LAT); i++) begin
                pi0_q[i][l] <= pi0_q[i-1][l];
                pi1_q[i][l] <= pi1_q[i-1][l];
                pu_q[i][l]  <= pu_q[i-1][l];
                pt_q[i][l]  <= pt_q[i-1][l];
            end
            if (pv_q[MUL_LAT-1]) begin
                if (psc_q[MUL_LAT-1]) begin
                    mem[pi0_q[MUL_LAT-1][l]] <= pt_q[MUL_LAT-1][l];
                end else begin
                    mem[pi0_q[MUL_LAT-1][l]] <= add_mod(pu_q[MUL_LAT-1][l], pt_q[MUL_LAT-1][l]);
                    mem[pi1_q[MUL_LAT-1][l]] <= sub_mod(pu_q[MUL_LAT-1][l], pt_q[MUL_LAT-1][l]);
                end
            end
        end
    end

    assign out_valid   = (state_q == StUnload);
    assign out_last    = out_valid && (cnt_q == CW'(N - 1));
    assign out_data    = out_valid ? mem[cnt_q[LOGN-1:0]] : '0;
    assign done        = done_q;
    assign len_err     = len_err_q;
    assign frame_count = fc_q;

endmodule

// File: tb/tb_parallel_ntt_stream.sv
// Scoreboard bench for parallel_ntt_stream at N=8, q=17 against a direct-DFT reference model.

module tb_parallel_ntt_stream;

    localparam int W      = 8;
    localparam int LOGN   = 3;
    localparam int NN     = 8;
    localparam int LANES  = 2;
    localparam int Q      = 17;
    localparam int ML     = 4;
    localparam int BUDGET = LOGN * (NN / (2 * LANES) + ML + 2) + NN + 4;

    typedef int frame_t [8];

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         in_last = 1'b0;
    logic         in_mode = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         busy, done, len_err;
    logic [31:0]  frame_count;

    parallel_ntt_stream #(
        .WIDTH(W), .LOGN(LOGN), .LANES(LANES), .MODULUS(8'd17), .OMEGA(8'd2),
        .OMEGA_INV(8'd9), .N_INV(8'd15), .MUL_LAT(ML)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy), .done(done),
        .len_err(len_err), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int n_tests  = 0;
    int n_fail   = 0;
    int exp_q[$];
    bit last_q[$];
    int done_cnt = 0;
    int lerr_cnt = 0;
    bit rdy_rand = 1'b0;
    int fc_model = 0;
    int dn_model = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int pw(input int b, input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % Q;
        return r;
    endfunction

    // Reference: X[k] = sum x[j] w^(jk) mod q, scaled by N^-1 for the inverse.
    function automatic frame_t dft(input frame_t x, input bit inv);
        frame_t y;
        int w = inv ? 9 : 2;
        for (int k = 0; k < NN; k++) begin
            int s = 0;
            for (int j = 0; j < NN; j++) s = (s + (x[j] % Q) * pw(w, j * k)) % Q;
            y[k] = inv ? (s * 15) % Q : s;
        end
        return y;
    endfunction

    // Output monitor: drives out_ready, pops the scoreboard, checks stall stability.
    initial begin
        bit       prev_stall = 1'b0;
        bit       prev_last  = 1'b0;
        int       prev_data  = 0;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (len_err) lerr_cnt++;
            out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
                check("stall_last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("out_data", out_data, exp_q.pop_front());
                    check("out_last", out_last, last_q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic push_exp(input frame_t e);
        for (int k = 0; k < NN; k++) begin
            exp_q.push_back(e[k]);
            last_q.push_back(k == NN - 1);
        end
    endtask

    task automatic send(input frame_t v, input bit mode, input int last_at, input bit gaps);
        @(negedge clk);
        for (int j = 0; j < NN; j++) begin
            int t = 0;
            if (last_at >= 0 && j > last_at) break;
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = W'(v[j]);
            in_mode  = (j == 0) ? mode : 1'($urandom_range(0, 1));
            in_last  = (j == last_at);
            while (!in_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            check("in_ready_wait", in_ready, 1);
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while (done_cnt < dn_model && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("done_pulses", done_cnt, dn_model);
        check("scoreboard_drained", exp_q.size(), 0);
        check("frame_count", frame_count, fc_model);
    endtask

    task automatic run_frame(input frame_t v, input bit mode, input int last_at,
                             input frame_t e, input bit gaps);
        int lat = 0;
        push_exp(e);
        send(v, mode, last_at, gaps);
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        n_tests++;
        if (lat > BUDGET) begin
            n_fail++;
            $display("FAIL compute_cycles: got %0d, limit %0d", lat, BUDGET);
        end
        dn_model++;
        fc_model++;
        wait_done();
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("idle_in_ready", in_ready, 1);
        check("idle_busy", busy, 0);
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 1);
        check("rst_done", done, 0);
        check("rst_len_err", len_err, 0);
        check("rst_frame_count", frame_count, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t v, e;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("init_busy", busy, 1);
        check("init_in_ready", in_ready, 0);
        wait_idle();

        v = '{1, 0, 0, 0, 0, 0, 0, 0};
        e = '{1, 1, 1, 1, 1, 1, 1, 1};
        run_frame(v, 1'b0, 7, e, 1'b0);
        v = '{0, 1, 0, 0, 0, 0, 0, 0};
        e = '{1, 2, 4, 8, 16, 15, 13, 9};
        run_frame(v, 1'b0, 7, e, 1'b0);
        v = '{1, 2, 4, 8, 16, 15, 13, 9};
        e = '{0, 1, 0, 0, 0, 0, 0, 0};
        run_frame(v, 1'b1, 7, e, 1'b0);
        v = '{8, 0, 0, 0, 0, 0, 0, 0};
        e = '{1, 1, 1, 1, 1, 1, 1, 1};
        run_frame(v, 1'b1, 7, e, 1'b0);
        v = '{1, 1, 1, 18, 1, 1, 1, 1};
        e = '{8, 0, 0, 0, 0, 0, 0, 0};
        run_frame(v, 1'b0, 7, e, 1'b0);

        // Early in_last on the third beat drops the frame.
        v = '{3, 5, 7, 0, 0, 0, 0, 0};
        send(v, 1'b0, 2, 1'b0);
        repeat (3) @(negedge clk);
        check("early_last_len_err", lerr_cnt, 1);
        check("early_last_frame_count", frame_count, fc_model);
        check("early_last_idle", busy, 0);
        v = '{4, 9, 0, 2, 11, 16, 1, 5};
        run_frame(v, 1'b0, 7, dft(v, 1'b0), 1'b0);

        // Missing in_last on the final beat still processes the frame.
        for (int j = 0; j < NN; j++) v[j] = $urandom_range(0, 255);
        run_frame(v, 1'b1, -1, dft(v, 1'b1), 1'b0);
        check("missing_last_len_err", lerr_cnt, 2);

        rdy_rand = 1'b1;
        for (int f = 0; f < 6; f++) begin
            bit m = 1'($urandom_range(0, 1));
            for (int j = 0; j < NN; j++) v[j] = $urandom_range(0, 255);
            run_frame(v, m, 7, dft(v, m), 1'b1);
        end
        rdy_rand = 1'b0;

        // Reset in the middle of COMPUTE abandons the frame without output.
        for (int j = 0; j < NN; j++) v[j] = $urandom_range(0, 16);
        send(v, 1'b0, 7, 1'b0);
        repeat (5) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reinit_busy", busy, 1);
        check("reinit_in_ready", in_ready, 0);
        wait_idle();
        fc_model = 0;
        check("post_reset_done_pulses", done_cnt, dn_model);
        for (int j = 0; j < NN; j++) v[j] = $urandom_range(0, 255);
        run_frame(v, 1'b1, 7, dft(v, 1'b1), 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/parallel_ntt_stream.md
PARALLEL_NTT_STREAM -- requirements
Module: parallel_ntt_stream

Interface
REQ-001 SHALL have parameters: WIDTH=64, coefficient width; LOGN=12, transform size N=2^LOGN; LANES=8, butterflies per cycle (power of two, 1..N/2); MODULUS=64'hffffffff00000001, prime q; OMEGA, primitive N-th root of unity mod q; OMEGA_INV, OMEGA^-1 mod q; N_INV, N^-1 mod q; MUL_LAT=4, modular-multiplier pipeline depth.
REQ-002 SHALL have ports: clk  in  1  sole clock; rst  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: in_valid  in  1; in_ready  out  1; in_data  in  WIDTH  coefficient; in_last  in  1  final beat of frame; in_mode  in  1  0=forward, 1=inverse, sampled on first beat.
REQ-004 SHALL have ports: out_valid  out  1; out_ready  in  1; out_data  out  WIDTH; out_last  out  1.
REQ-005 SHALL have ports: busy  out  1; done  out  1  one-cycle pulse; len_err  out  1  one-cycle pulse; frame_count  out  32  completed frames.
REQ-006 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-007 SHALL implement states INIT, IDLE, LOAD, COMPUTE, UNLOAD.
REQ-008 INIT SHALL compute twiddles OMEGA^i and OMEGA_INV^i mod q for i<N/2 sequentially, then go to IDLE; in_ready=0 and busy=1 throughout.
REQ-009 in_ready SHALL be 1 in IDLE and LOAD only; a beat transfers when in_valid&&in_ready.
REQ-010 IDLE SHALL move to LOAD on the first transferred beat, capturing in_mode and storing that beat as x[0].
REQ-011 Beat j of a frame SHALL be stored as x[j], reduced mod q if in_data>=q.
REQ-012 in_last on beat j<N-1 SHALL drop the frame, pulse len_err, and return to IDLE with frame_count unchanged.
REQ-013 Beat N-1 SHALL end LOAD and enter COMPUTE regardless of in_last; if in_last=0 there, len_err SHALL pulse and the frame is still processed.
REQ-014 Forward mode SHALL produce X[k]=sum_j x[j]*OMEGA^(jk) mod q; inverse SHALL produce N_INV*sum_j x[j]*OMEGA_INV^(jk) mod q.
REQ-015 Input and output order SHALL both be natural; any bit-reversal is internal.
REQ-016 COMPUTE SHALL issue up to LANES radix-2 butterflies per cycle across LOGN stages, stalling a stage until all its products retire (no RAW hazard).
REQ-017 All arithmetic SHALL be exact mod q: sums/differences use WIDTH+1-bit intermediates with conditional subtract, products use 2*WIDTH-bit intermediates; all stored values SHALL be <q.
REQ-018 COMPUTE SHALL finish within LOGN*(N/(2*LANES)+MUL_LAT+2)+N+4 cycles, inverse scaling included.
REQ-019 UNLOAD SHALL present X[0..N-1] in order; out_last=1 only with X[N-1]; out_valid=0 in all other states.
REQ-020 While out_valid&&!out_ready, out_data, out_last and out_valid SHALL hold stable.
REQ-021 After the X[N-1] transfer: done SHALL pulse next cycle, frame_count SHALL increment (wrapping at 2^32), and state SHALL return to IDLE.
REQ-022 busy SHALL be 1 in INIT, LOAD, COMPUTE and UNLOAD, and 0 in IDLE.
REQ-023 Input beats SHALL not be accepted during COMPUTE or UNLOAD (in_ready=0).

Reset
REQ-024 rst SHALL, on the clock edge, force state INIT and set in_ready=0, out_valid=0, out_last=0, out_data=0, busy=1, done=0, len_err=0, frame_count=0.
REQ-025 Assertion of rst in any state SHALL abandon the frame in progress; no partial output SHALL be emitted.
REQ-026 Coefficient memory contents after reset SHALL be don't-care; twiddles SHALL be regenerated in INIT.

Verification (N=8, q=17, OMEGA=2, OMEGA_INV=9, N_INV=15, WIDTH=8)
REQ-027 Forward [1,0,0,0,0,0,0,0] -> out [1,1,1,1,1,1,1,1], out_last on 8th beat, done pulse, frame_count=1.
REQ-028 Forward [0,1,0,0,0,0,0,0] -> [1,2,4,8,16,15,13,9]; inverse of that -> [0,1,0,0,0,0,0,0].
REQ-029 Inverse [8,0,0,0,0,0,0,0] -> [1,1,1,1,1,1,1,1]; forward all-ones with one input coded as 18 -> [8,0,0,0,0,0,0,0].
REQ-030 Random out_ready toggling -> 8 beats with no loss or duplication, data stable while stalled.
REQ-031 in_last on 3rd beat -> len_err pulse, no output, frame_count unchanged; a following good frame is correct.
REQ-032 rst asserted mid-COMPUTE -> all outputs at reset values next cycle, busy through INIT, then a correct next frame.
